// File: rtl/fpga_cfg_pkg.sv
// Shared types and sizing helpers for the streaming FPGA configuration loader.
package fpga_cfg_pkg;

    // Loader states; StChk and StErr are only reachable with FPGA_CFG_CHECKSUM_EN.
    typedef enum logic [2:0] {
        StIdle,
        StLutTt,
        StLutMode,
        StSw,
        StChk,
        StDone,
        StErr
    } cfg_state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Index width that stays at least one bit for single-entry tables.
    function automatic int unsigned idx_w(input int unsigned count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

    // Truth table plus one mode/flop-select bit.
    function automatic int unsigned lut_cfg_w(input int unsigned lut_k);
        return (32'd1 << lut_k) + 1;
    endfunction

    // Two words per LUT, one per switch box (checksum word not included).
    function automatic int unsigned total_words(input int unsigned n_lut,
                                                input int unsigned n_sw);
        return 2 * n_lut + n_sw;
    endfunction

endpackage

// File: rtl/fpga_cfg_checksum.sv
// Running XOR accumulator over accepted configuration words, with a compare
// against the word currently presented on the stream.
module fpga_cfg_checksum #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [WORD_W-1:0] data,
    output logic              match
);

    logic [WORD_W-1:0] acc_q;

    // Accumulate accepted words; a new load restarts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_q ^ data;
        end
    end

    assign match = (data == acc_q);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streaming configuration loader: LUT truth-table/mode word pairs, then one
// word per switch box, driven onto flat configuration buses.
// Optional build macro FPGA_CFG_CHECKSUM_EN appends an XOR checksum word.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LUT_K  = 5,
    parameter int unsigned N_LUT  = 14,
    parameter int unsigned N_SW   = 22,
    localparam int unsigned LUT_CFG_W   = lut_cfg_w(LUT_K),
    localparam int unsigned TOTAL_WORDS = total_words(N_LUT, N_SW),
    localparam int unsigned CNT_W       = clog2(TOTAL_WORDS + 2)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         cfg_valid,
    input  logic [WORD_W-1:0]            cfg_data,
    output logic                         cfg_ready,
    output logic [N_LUT*LUT_CFG_W-1:0]   lut_cfg,
    output logic [N_SW*WORD_W-1:0]       sw_cfg,
    output logic [CNT_W-1:0]             word_cnt,
    output logic                         done,
    output logic                         fabric_en,
    output logic                         cfg_error
);

    localparam int unsigned TT_W   = 1 << LUT_K;
    localparam int unsigned LIDX_W = idx_w(N_LUT);
    localparam int unsigned SIDX_W = idx_w(N_SW);
    localparam logic [LIDX_W-1:0] LUT_LAST = LIDX_W'(N_LUT - 1);
    localparam logic [SIDX_W-1:0] SW_LAST  = SIDX_W'(N_SW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

`ifdef FPGA_CFG_CHECKSUM_EN
    localparam cfg_state_t LOAD_END = StChk;
`else
    localparam cfg_state_t LOAD_END = StDone;
`endif
    // Without a checksum stage the last data word completes the load directly.
    localparam bit END_IS_DONE = (LOAD_END == StDone);

    cfg_state_t        state_q;
    logic [LIDX_W-1:0] lut_idx_q;
    logic [SIDX_W-1:0] sw_idx_q;
    logic              accept;

    // Ready depends only on state so the source sees no combinational loop.
    always_comb begin
        cfg_ready = 1'b0;
        unique case (state_q)
            StLutTt, StLutMode, StSw, StChk: cfg_ready = 1'b1;
            default:                         cfg_ready = 1'b0;
        endcase
    end

    assign accept = cfg_valid && cfg_ready;

`ifdef FPGA_CFG_CHECKSUM_EN
    logic cfg_error_q;
    logic chk_clear;
    logic chk_accept;
    logic chk_match;

    assign chk_clear  = start && (state_q inside {StIdle, StDone, StErr});
    assign chk_accept = accept && (state_q != StChk);
    assign cfg_error  = cfg_error_q;

    fpga_cfg_checksum #(
        .WORD_W (WORD_W)
    ) u_checksum (
        .clock  (clock),
        .reset  (reset),
        .clear  (chk_clear),
        .accept (chk_accept),
        .data   (cfg_data),
        .match  (chk_match)
    );
`else
    assign cfg_error = 1'b0;
`endif

    // Load sequencer: walks the fixed word order and writes the config buses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            lut_idx_q <= '0;
            sw_idx_q  <= '0;
            word_cnt  <= '0;
            done      <= 1'b0;
            fabric_en <= 1'b0;
            lut_cfg   <= '0;
            sw_cfg    <= '0;
`ifdef FPGA_CFG_CHECKSUM_EN
            cfg_error_q <= 1'b0;
`endif
        end else begin
            if (accept && (word_cnt != CNT_MAX)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    // Old configuration stays on the buses until overwritten.
                    if (start) begin
                        state_q   <= StLutTt;
                        lut_idx_q <= '0;
                        sw_idx_q  <= '0;
                        word_cnt  <= '0;
                        done      <= 1'b0;
                        fabric_en <= 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
                        cfg_error_q <= 1'b0;
`endif
                    end
                end
                StLutTt: begin
                    if (accept) begin
                        lut_cfg[int'(lut_idx_q)*LUT_CFG_W +: TT_W] <= cfg_data[TT_W-1:0];
                        state_q <= StLutMode;
                    end
                end
                StLutMode: begin
                    if (accept) begin
                        lut_cfg[int'(lut_idx_q)*LUT_CFG_W + TT_W] <= cfg_data[0];
                        if (lut_idx_q == LUT_LAST) begin
                            if (N_SW == 0) begin
                                state_q   <= LOAD_END;
                                done      <= END_IS_DONE;
                                fabric_en <= END_IS_DONE;
                            end else begin
                                state_q <= StSw;
                            end
                        end else begin
                            lut_idx_q <= lut_idx_q + LIDX_W'(1);
                            state_q   <= StLutTt;
                        end
                    end
                end
                StSw: begin
                    if (accept) begin
                        sw_cfg[int'(sw_idx_q)*WORD_W +: WORD_W] <= cfg_data;
                        if (sw_idx_q == SW_LAST) begin
                            state_q   <= LOAD_END;
                            done      <= END_IS_DONE;
                            fabric_en <= END_IS_DONE;
                        end else begin
                            sw_idx_q <= sw_idx_q + SIDX_W'(1);
                        end
                    end
                end
                StChk: begin
`ifdef FPGA_CFG_CHECKSUM_EN
                    if (accept) begin
                        if (chk_match) begin
                            state_q   <= StDone;
                            done      <= 1'b1;
                            fabric_en <= 1'b1;
                        end else begin
                            state_q     <= StErr;
                            cfg_error_q <= 1'b1;
                        end
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: the driver pushes the expected final
// image when a load is issued, a monitor pops and compares on completion.
module tb_fpga_cfg_loader;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LUT_K  = 5;
    localparam int unsigned N_LUT  = 14;
    localparam int unsigned N_SW   = 22;
    localparam int unsigned TT_W   = 1 << LUT_K;
    localparam int unsigned LCW    = TT_W + 1;
    localparam int unsigned TOTAL  = 2 * N_LUT + N_SW;
    localparam int unsigned CNT_W  = $clog2(TOTAL + 2);
`ifdef FPGA_CFG_CHECKSUM_EN
    localparam int unsigned NW = TOTAL + 1;
`else
    localparam int unsigned NW = TOTAL;
`endif

    typedef logic [1023:0] wide_t;
    typedef struct {
        logic [N_LUT*LCW-1:0]   lut;
        logic [N_SW*WORD_W-1:0] sw;
        int unsigned            cnt;
        bit                     ok;
    } exp_t;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   cfg_valid;
    logic [WORD_W-1:0]      cfg_data;
    logic                   cfg_ready;
    logic [N_LUT*LCW-1:0]   lut_cfg;
    logic [N_SW*WORD_W-1:0] sw_cfg;
    logic [CNT_W-1:0]       word_cnt;
    logic                   done;
    logic                   fabric_en;
    logic                   cfg_error;

    int    checks = 0;
    int    errors = 0;
    int    pushes = 0;
    int    pops   = 0;
    exp_t  sb[$];
    exp_t  last_exp;
    logic [WORD_W-1:0] img [NW];

    fpga_cfg_loader #(
        .WORD_W (WORD_W),
        .LUT_K  (LUT_K),
        .N_LUT  (N_LUT),
        .N_SW   (N_SW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .lut_cfg   (lut_cfg),
        .sw_cfg    (sw_cfg),
        .word_cnt  (word_cnt),
        .done      (done),
        .fabric_en (fabric_en),
        .cfg_error (cfg_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: word 2i is LUT i truth table, word 2i+1 bit 0 its mode bit,
    // then switch boxes in order.
    function automatic exp_t model(input bit ok);
        exp_t e;
        e.lut = '0;
        e.sw  = '0;
        e.cnt = NW;
        e.ok  = ok;
        for (int i = 0; i < N_LUT; i++) begin
            e.lut[i*LCW +: LCW] = {img[2*i+1][0], img[2*i][TT_W-1:0]};
        end
        for (int j = 0; j < N_SW; j++) begin
            e.sw[j*WORD_W +: WORD_W] = img[2*N_LUT+j];
        end
        return e;
    endfunction

    task automatic new_image();
        logic [WORD_W-1:0] x;
        x = '0;
        for (int k = 0; k < TOTAL; k++) begin
            img[k] = WORD_W'($urandom);
            x ^= img[k];
        end
`ifdef FPGA_CFG_CHECKSUM_EN
        img[TOTAL] = x;
`endif
    endtask

`ifdef FPGA_CFG_CHECKSUM_EN
    task automatic corrupt_checksum();
        img[TOTAL] = img[TOTAL] ^ (WORD_W'(1) << $urandom_range(0, WORD_W - 1));
    endtask
`endif

    task automatic clear_last();
        last_exp.lut = '0;
        last_exp.sw  = '0;
        last_exp.cnt = 0;
        last_exp.ok  = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_lut"}, wide_t'(lut_cfg), '0);
        check({name, "_sw"}, wide_t'(sw_cfg), '0);
        check({name, "_flags"},
              wide_t'({word_cnt, done, fabric_en, cfg_error, cfg_ready}), '0);
    endtask

    // vmode: 0 valid held high, 1 valid toggling, 2 random valid.
    task automatic run_load(input int vmode, input int abort_at, input int start_at,
                            input bit ok);
        int   k;
        int   cyc;
        int   ready_bad;
        int   done_bad;
        bit   v;
        bit   pulsed;
        exp_t e;
        k = 0;
        cyc = 0;
        ready_bad = 0;
        done_bad = 0;
        pulsed = 1'b0;
        e = model(ok);
        if (abort_at < 0) begin
            sb.push_back(e);
            pushes++;
        end
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_clears", wide_t'({word_cnt, done, fabric_en, cfg_error}), '0);
        check("retain_lut", wide_t'(lut_cfg), wide_t'(last_exp.lut));
        check("retain_sw", wide_t'(sw_cfg), wide_t'(last_exp.sw));
        while (k < int'(NW) && k != abort_at && cyc < 2000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = $urandom_range(0, 1) == 1;
            endcase
            cfg_valid = v;
            cfg_data  = v ? img[k] : WORD_W'($urandom);
            start     = (k == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            #1;
            if (cfg_ready !== 1'b1) ready_bad++;
            if (done !== 1'b0 || fabric_en !== 1'b0) done_bad++;
            @(negedge clock);
            if (v) k++;
            cyc++;
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("ready_during_load", wide_t'(ready_bad), '0);
        check("done_early", wide_t'(done_bad), '0);
        if (abort_at < 0) begin
            check("accepted_all", wide_t'(k), wide_t'(NW));
            if (vmode == 0) check("ready_cycles", wide_t'(cyc), wide_t'(NW));
            #1;
            check("done_latency", wide_t'({done, fabric_en}), ok ? wide_t'(3) : '0);
            check("ready_after", wide_t'(cfg_ready), '0);
            last_exp = e;
        end
    endtask

    // Monitor: compare the finished image whenever a load completes or fails.
    initial begin
        logic done_prev;
        logic err_prev;
        exp_t e;
        done_prev = 1'b0;
        err_prev  = 1'b0;
        forever begin
            @(negedge clock);
            if ((done === 1'b1 && !done_prev) || (cfg_error === 1'b1 && !err_prev)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got done=%0b err=%0b want none",
                             done, cfg_error);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    check("mon_lut", wide_t'(lut_cfg), wide_t'(e.lut));
                    check("mon_sw", wide_t'(sw_cfg), wide_t'(e.sw));
                    check("mon_word_cnt", wide_t'(word_cnt), wide_t'(e.cnt));
                    check("mon_status", wide_t'({done, fabric_en, cfg_error}),
                          e.ok ? wide_t'(3'b110) : wide_t'(3'b001));
                end
            end
            done_prev = done;
            err_prev  = cfg_error;
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        clear_last();
        #12;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        new_image();
        run_load(0, -1, -1, 1'b1);
        run_load(1, -1, -1, 1'b1);

        new_image();
        run_load(2, 20, -1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        clear_last();
        @(negedge clock);
        reset = 1'b0;

        new_image();
        run_load(0, -1, -1, 1'b1);
        new_image();
        run_load(2, -1, 10, 1'b1);
        new_image();
        run_load(0, -1, -1, 1'b1);
`ifdef FPGA_CFG_CHECKSUM_EN
        new_image();
        corrupt_checksum();
        run_load(0, -1, -1, 1'b0);
        new_image();
        run_load(2, -1, -1, 1'b1);
`endif
        repeat (3) @(negedge clock);
        check("sb_drained", wide_t'(sb.size()), '0);
        check("monitor_pops", wide_t'(pops), wide_t'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
Streaming configuration loader for the parametrised FPGA fabric. It replaces per-cell hierarchical preloading of LUT memories and switch-box configure registers. Words arrive on a valid/ready stream in fixed order: for each LUT, a truth-table word then a mode word; then one word per switch box. The loader drives flat configuration buses into the fabric and raises fabric_en once a complete image is loaded.

Parameters:
WORD_W, 32, configuration word width (>= 2**LUT_K)
LUT_K, 5, LUT input count; truth table is 2**LUT_K bits
N_LUT, 14, number of LUT cells
N_SW, 22, number of switch-box configure registers
(derived) LUT_CFG_W = 2**LUT_K+1; TOTAL_WORDS = 2*N_LUT+N_SW

Ports:
clock  in  1  fabric clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begin a new load
cfg_valid  in  1  cfg_data valid
cfg_data  in  WORD_W  configuration word
cfg_ready  out  1  loader accepts a word this cycle
lut_cfg  out  N_LUT*LUT_CFG_W  LUT i at [i*LUT_CFG_W +: LUT_CFG_W]; bit LUT_CFG_W-1 is the mode/flop-select bit
sw_cfg  out  N_SW*WORD_W  switch j at [j*WORD_W +: WORD_W]
word_cnt  out  clog2(TOTAL_WORDS+2)  words accepted in the current load
done  out  1  load complete
fabric_en  out  1  fabric may run; low while loading
cfg_error  out  1  load failed (CFG_CHECKSUM_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, counters 0.
- Accept = cfg_valid && cfg_ready. cfg_ready is combinational from state: 1 in LUT_TT, LUT_MODE, SW and CHK, else 0.
- States: IDLE, LUT_TT, LUT_MODE, SW, CHK (macro only), DONE, ERR.
- IDLE/DONE/ERR + start -> LUT_TT; on that edge clear word_cnt, done, fabric_en and cfg_error. Existing lut_cfg/sw_cfg are retained until overwritten.
- start in LUT_TT/LUT_MODE/SW/CHK: ignored.
- LUT_TT accept: lut_cfg[lut_idx] truth-table field <= cfg_data[2**LUT_K-1:0]; upper bits are ignored. Go to LUT_MODE.
- LUT_MODE accept: mode bit <= cfg_data[0].
  - If lut_idx==N_LUT-1, go to SW (or to DONE if N_SW==0).
  - Otherwise lut_idx++ and go to LUT_TT.
- SW accept: sw_cfg[sw_idx] <= cfg_data.
  - If sw_idx==N_SW-1, go to DONE (to CHK with the macro).
  - Otherwise sw_idx++.
- word_cnt increments on every accept and saturates at its maximum.
- Latency: configuration outputs update on the accepting edge. done and fabric_en are 1 from the cycle after the final word is accepted and stay high until the next start or reset.
- cfg_valid low stalls the load indefinitely; no timeout.
- Reset mid-load clears everything, including partially written configuration; fabric_en stays 0.

Optional Feature:
FPGA_CFG_CHECKSUM_EN:
- Defined: the loader keeps a running XOR of all accepted data words. After the last switch word, state CHK expects one extra word.
  - Word == running XOR: go to DONE.
  - Otherwise: go to ERR, with cfg_error=1, done=0, fabric_en=0 until the next start or reset.
  - word_cnt counts the checksum word.
- Undefined: no CHK or ERR state is reachable, cfg_error is tied 0, and the load ends after TOTAL_WORDS.

Decomposition:
- Package fpga_cfg_pkg holds:
  - the state enum (cfg_state_t);
  - functions for LUT_CFG_W and TOTAL_WORDS;
  - a clog2 helper.
- One sub-module, fpga_cfg_checksum: the XOR accumulator with clear/accept/compare. Instantiate it only under the macro.

Test Plan:
- Defaults, reset then start, 50 words with cfg_valid held 1: cfg_ready high for exactly 50 cycles; done=fabric_en=1 the cycle after word 50; word_cnt=50; LUT 0 field = {word1[0], word0}; sw_cfg switch 21 = word49.
- Same stream with cfg_valid toggled 1-0-1 each cycle: identical final outputs; done asserts 1 cycle after the 50th accept.
- Reset asserted after word 20, then released: all outputs 0 immediately (asynchronous). A fresh full load then succeeds.
- start pulsed after word 10: ignored. Completion and contents are unchanged.
- Reload after DONE with a different image: fabric_en drops on the start edge, and the new values replace the old.
- Macro defined, good XOR word as 51st word → done=1, cfg_error=0. Corrupted checksum → cfg_error=1, fabric_en=0.
